branch_resolve_tracker: RTL and testbench
=========================================

// Module: branch_resolve_tracker
// PURPOSE
//  Write side of the prediction tables. Tracks in-flight predicted branches in
//  program order and keeps the speculative and committed global history.
//  On resolution it drives the table update/evict port, flags mispredicts and
//  repairs history. Sits between fetch (predictions) and execute (resolutions).
// PARAMETERS
//  PC_W   10  branch PC width
//  IDX_W  3   table index width; index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W]
//  HIST_W 3   global history width
//  DEPTH  4   in-flight FIFO entries (power of two)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  pred_valid   in   1       fetch issues a predicted branch
//  pred_pc      in   PC_W    PC of that branch
//  pred_taken   in   1       direction predicted by the tables
//  pred_ready   out  1       FIFO not full (combinational from count)
//  lookup_hist  out  HIST_W  speculative history for table lookup
//  res_valid    in   1       oldest in-flight branch resolved this cycle
//  res_taken    in   1       actual direction
//  flush        in   1       pipeline flush; discard all in-flight entries
//  mispredict   out  1       registered 1-cycle pulse: predicted != actual
//  evict        out  1       registered pulse: clear table evict_idx
//  evict_idx    out  IDX_W   table to clear; held until next eviction
//  upd_we       out  1       registered pulse: write one table entry
//  upd_pc       out  PC_W    PC of resolved branch
//  upd_hist     out  HIST_W  history snapshot taken at prediction time
//  upd_taken    out  1       actual direction to train with
//  inflight     out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, spec_hist = commit_hist = 0, tag table all invalid, all
//   registered outputs 0, pred_ready = 1. Applies immediately, even mid-op.
//  Push when pred_valid & pred_ready: store {pc, spec_hist, pred_taken};
//   spec_hist <= {spec_hist[HIST_W-2:0], pred_taken}. pred_ready = 0 when
//   full, even if a pop occurs in the same cycle.
//  Pop when res_valid & count != 0: oldest entry E enters stage 1. res_valid
//   with empty FIFO is ignored (no pulses, no state change).
//   commit_hist <= {commit_hist[HIST_W-2:0], res_taken}.
//  Stage 1 (cycle after pop): mispredict = (E.pred != res_taken). If
//   tag[idx] valid and != E tag: evict = 1, evict_idx = idx.
//   tag[idx] <= E tag, valid.
//  Stage 2 (two cycles after pop): upd_we = 1 with upd_pc/upd_hist/upd_taken
//   from E. An eviction is always at least one cycle before the update for
//   the same index. Back-to-back pops are fully pipelined.
//  Mispredict at pop: all remaining entries and any same-cycle push are
//   discarded. spec_hist <= new commit_hist.
//  flush: FIFO cleared and same-cycle push dropped. A same-cycle pop is still
//   processed first, then spec_hist <= updated commit_hist.
//  Pointers wrap modulo DEPTH. History shifts drop the MSB.
// TESTING
//  1 Reset: 3 pushes, then rst_n=0 -> inflight=0, lookup_hist=000, upd_we=0,
//    pred_ready=1 in the same cycle.
//  2 Push 0x005(T), 0x00D(N) -> lookup_hist 000->001->010. Resolve T, N ->
//    upd 0x005/hist 000/T. evict=1, idx=5 before upd 0x00D/hist 001/N.
//  3 Push 4 -> pred_ready=0, inflight=4. 5th push ignored. Pop 1 ->
//    pred_ready=1.
//  4 Push A(pred T), B(pred N). Resolve A=N -> mispredict=1 next cycle,
//    inflight=0, lookup_hist=000. B never updates.
//  5 flush with res_valid on 2-entry FIFO -> one upd_we for the oldest entry,
//    inflight=0, lookup_hist=commit_hist.
//  6 res_valid, FIFO empty -> no mispredict/evict/upd_we, histories unchanged.

Source files
------------

// File: rtl/branch_resolve_tracker.sv
// Write side of the branch prediction tables: in-order tracking of predicted
// branches, speculative/committed global history, table update/evict pipeline.
module branch_resolve_tracker #(
  parameter int PC_W   = 10,
  parameter int IDX_W  = 3,
  parameter int HIST_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [HIST_W-1:0]        lookup_hist,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     mispredict,
  output logic                     evict,
  output logic [IDX_W-1:0]         evict_idx,
  output logic                     upd_we,
  output logic [PC_W-1:0]          upd_pc,
  output logic [HIST_W-1:0]        upd_hist,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   inflight
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = PC_W - IDX_W;
  localparam int TBL_N = 1 << IDX_W;

  logic [PC_W-1:0]   fifo_pc   [DEPTH];
  logic [HIST_W-1:0] fifo_hist [DEPTH];
  logic              fifo_pred [DEPTH];
  logic [TAG_W-1:0]  tag_mem   [TBL_N];
  logic [TBL_N-1:0]  tag_valid;

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [HIST_W-1:0] spec_hist, commit_hist, commit_next;

  logic              s1_valid;
  logic [PC_W-1:0]   s1_pc;
  logic [HIST_W-1:0] s1_hist;
  logic              s1_taken;

  logic              do_push, do_pop, mis_now, evict_now, clear_all;
  logic [PC_W-1:0]   head_pc;
  logic [HIST_W-1:0] head_hist;
  logic              head_pred;
  logic [IDX_W-1:0]  head_idx;
  logic [TAG_W-1:0]  head_tag;

  assign pred_ready  = (count != CNT_W'(DEPTH));
  assign lookup_hist = spec_hist;
  assign inflight    = count;

  assign head_pc   = fifo_pc[rd_ptr];
  assign head_hist = fifo_hist[rd_ptr];
  assign head_pred = fifo_pred[rd_ptr];
  assign head_idx  = head_pc[IDX_W-1:0];
  assign head_tag  = head_pc[PC_W-1:IDX_W];

  assign do_push     = pred_valid & pred_ready;
  assign do_pop      = res_valid & (count != '0);
  assign mis_now     = do_pop & (head_pred != res_taken);
  assign evict_now   = do_pop & tag_valid[head_idx] & (tag_mem[head_idx] != head_tag);
  assign clear_all   = flush | mis_now;
  assign commit_next = do_pop ? {commit_hist[HIST_W-2:0], res_taken} : commit_hist;

  // Payload storage needs no reset: occupancy and tag_valid gate every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_pc[wr_ptr]   <= pred_pc;
      fifo_hist[wr_ptr] <= spec_hist;
      fifo_pred[wr_ptr] <= pred_taken;
    end
    if (do_pop) tag_mem[head_idx] <= head_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      spec_hist   <= '0;
      commit_hist <= '0;
      tag_valid   <= '0;
      mispredict  <= 1'b0;
      evict       <= 1'b0;
      evict_idx   <= '0;
      s1_valid    <= 1'b0;
      s1_pc       <= '0;
      s1_hist     <= '0;
      s1_taken    <= 1'b0;
      upd_we      <= 1'b0;
      upd_pc      <= '0;
      upd_hist    <= '0;
      upd_taken   <= 1'b0;
    end else begin
      commit_hist <= commit_next;
      // A flush or mispredict squashes the FIFO and any same-cycle push.
      if (clear_all) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        spec_hist <= commit_next;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push) begin
          wr_ptr    <= wr_ptr + 1'b1;
          spec_hist <= {spec_hist[HIST_W-2:0], pred_taken};
        end
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end

      mispredict <= mis_now;
      evict      <= evict_now;
      if (evict_now) evict_idx <= head_idx;
      if (do_pop) tag_valid[head_idx] <= 1'b1;

      // Eviction leaves one edge ahead of the matching table write.
      s1_valid <= do_pop;
      if (do_pop) begin
        s1_pc    <= head_pc;
        s1_hist  <= head_hist;
        s1_taken <= res_taken;
      end
      upd_we <= s1_valid;
      if (s1_valid) begin
        upd_pc    <= s1_pc;
        upd_hist  <= s1_hist;
        upd_taken <= s1_taken;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Randomized self-checking bench for branch_resolve_tracker against a
// queue-based model of in-flight branches, histories and the tag table.
module tb_branch_resolve_tracker;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic [9:0] pred_pc = '0;
  logic       pred_taken = 1'b0;
  logic       pred_ready;
  logic [2:0] lookup_hist;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic       flush = 1'b0;
  logic       mispredict;
  logic       evict;
  logic [2:0] evict_idx;
  logic       upd_we;
  logic [9:0] upd_pc;
  logic [2:0] upd_hist;
  logic       upd_taken;
  logic [2:0] inflight;

  branch_resolve_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .lookup_hist(lookup_hist),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .mispredict(mispredict), .evict(evict), .evict_idx(evict_idx),
    .upd_we(upd_we), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int pc; int hist; int pred; } ent_t;

  int   num_checks = 0;
  int   num_fail = 0;
  ent_t m_q[$];
  int   m_spec, m_commit, m_evidx;
  int   m_tag[8];
  bit   m_tvalid[8];
  bit   pend_v;
  ent_t pend_e;
  int   pend_taken;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    num_checks++;
    if (obs != exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_spec = 0; m_commit = 0; m_evidx = 0;
    pend_v = 0;
    for (int i = 0; i < 8; i++) begin m_tvalid[i] = 0; m_tag[i] = 0; end
  endtask

  // Reset asserted mid-cycle; its effect must be visible at once.
  task automatic doReset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    pred_valid = 0; res_valid = 0; flush = 0;
    #1;
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_lookup_hist", lookup_hist, 0);
    checkOutput("rst_upd_we", upd_we, 0);
    checkOutput("rst_pred_ready", pred_ready, 1);
    modelReset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit pv, input int ppc, input bit pt,
                               input bit rv, input bit rt, input bit fl);
    ent_t e;
    bit   push, pop, exp_mis, exp_ev, exp_upd;
    ent_t upd_e;
    int   upd_t, idx, tg;
    @(negedge clk);
    pred_valid = pv; pred_pc = ppc[9:0]; pred_taken = pt;
    res_valid = rv; res_taken = rt; flush = fl;
    #1;
    checkOutput("pred_ready", pred_ready, int'(m_q.size() != DEPTH));
    checkOutput("inflight", inflight, m_q.size());
    checkOutput("lookup_hist", lookup_hist, m_spec);

    push = pv && (m_q.size() != DEPTH);
    pop  = rv && (m_q.size() != 0);
    exp_mis = 0; exp_ev = 0;
    exp_upd = pend_v; upd_e = pend_e; upd_t = pend_taken;
    pend_v = 0;
    if (pop) begin
      e = m_q.pop_front();
      exp_mis = (e.pred != int'(rt));
      m_commit = ((m_commit << 1) | int'(rt)) & 7;
      idx = e.pc % 8;
      tg  = e.pc / 8;
      if (m_tvalid[idx] && m_tag[idx] != tg) begin exp_ev = 1; m_evidx = idx; end
      m_tvalid[idx] = 1; m_tag[idx] = tg;
      pend_v = 1; pend_e = e; pend_taken = int'(rt);
    end
    if (fl || exp_mis) begin
      m_q.delete();
      m_spec = m_commit;
    end else if (push) begin
      e.pc = ppc & 1023; e.hist = m_spec; e.pred = int'(pt);
      m_q.push_back(e);
      m_spec = ((m_spec << 1) | int'(pt)) & 7;
    end

    @(posedge clk); #1;
    checkOutput("mispredict", mispredict, int'(exp_mis));
    checkOutput("evict", evict, int'(exp_ev));
    checkOutput("evict_idx", evict_idx, m_evidx);
    checkOutput("upd_we", upd_we, int'(exp_upd));
    if (exp_upd) begin
      checkOutput("upd_pc", upd_pc, upd_e.pc);
      checkOutput("upd_hist", upd_hist, upd_e.hist);
      checkOutput("upd_taken", upd_taken, upd_t);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    modelReset();
    @(negedge clk); rst_n = 1'b1;

    // Reset with entries in flight
    applyStimulus(1, 'h011, 1, 0, 0, 0);
    applyStimulus(1, 'h022, 0, 0, 0, 0);
    applyStimulus(1, 'h033, 1, 0, 0, 0);
    checkOutput("t1_inflight_pre", inflight, 3);
    doReset();

    // History shifting, update contents, eviction ordering
    applyStimulus(1, 'h005, 1, 0, 0, 0);
    checkOutput("t2_hist1", lookup_hist, 1);
    applyStimulus(1, 'h00D, 0, 0, 0, 0);
    checkOutput("t2_hist2", lookup_hist, 2);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("t2_evict", evict, 1);
    checkOutput("t2_evict_idx", evict_idx, 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_upd_pc", upd_pc, 'h00D);
    checkOutput("t2_upd_hist", upd_hist, 1);
    idle(2);

    // Full FIFO
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 'h100 + i, 0, 0, 0, 0);
    checkOutput("t3_full_ready", pred_ready, 0);
    checkOutput("t3_full_count", inflight, 4);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("t3_ready_after_pop", pred_ready, 1);
    idle(3);

    // Mispredict squashes younger entry
    doReset();
    applyStimulus(1, 'h0A3, 1, 0, 0, 0);
    applyStimulus(1, 'h0B1, 0, 0, 0, 0);
    applyStimulus(1, 'h0C2, 1, 1, 0, 0);
    checkOutput("t4_mispredict", mispredict, 1);
    checkOutput("t4_inflight", inflight, 0);
    checkOutput("t4_hist", lookup_hist, 0);
    idle(4);

    // Flush with a same-cycle resolve
    doReset();
    applyStimulus(1, 'h017, 1, 0, 0, 0);
    applyStimulus(1, 'h027, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("t5_inflight", inflight, 0);
    checkOutput("t5_hist", lookup_hist, 1);
    idle(4);

    // Resolve on empty FIFO
    doReset();
    applyStimulus(0, 0, 0, 1, 1, 0);
    idle(2);

    // Randomized traffic
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, int'($urandom_range(0, 1023)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 499) == 0) doReset();
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end
endmodule
